// File: rtl/vidmem_pkg.sv
// Shared encodings and framebuffer window defaults for the video memory arbiter.
package vidmem_pkg;

  localparam logic [1:0] STATE_IDLE      = 2'h0;
  localparam logic [1:0] STATE_GRANT_VGA = 2'h1;
  localparam logic [1:0] STATE_GRANT_CPU = 2'h2;

  typedef enum logic [1:0] {
    IDLE      = STATE_IDLE,
    GRANT_VGA = STATE_GRANT_VGA,
    GRANT_CPU = STATE_GRANT_CPU
  } state_t;

  localparam logic [31:0] VIDMEM_DEFAULT  = 32'h00c00000;
  localparam logic [31:0] VIDSIZE_DEFAULT = 32'h00100000;

  // Unsigned offset compare also rejects addresses below the base (they wrap high).
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    return (addr - base) < size;
  endfunction

endpackage

// File: rtl/vidmem_timeout.sv
// Per-transaction watchdog: counts granted cycles without an acknowledge.
module vidmem_timeout #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT) + 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Only raised while counting, so a same-cycle acknowledge always wins.
  assign hit = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/vidmem_arbiter.sv
// Arbitrates the single memory port between the VGA fetcher (fixed priority)
// and the CPU, with a starvation guard for the CPU and a per-transfer watchdog.
module vidmem_arbiter
  import vidmem_pkg::*;
#(
  parameter int          STARVE_LIMIT = 8,
  parameter int          TIMEOUT      = 64,
  parameter logic [31:0] VIDMEM       = VIDMEM_DEFAULT,
  parameter logic [31:0] VIDSIZE      = VIDSIZE_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        vga_read,
  input  logic [31:0] vga_address,
  output logic        vga_wait,
  output logic [23:0] vga_data,
  input  logic        cpu_cyc,
  input  logic        cpu_we,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_writedata,
  output logic [31:0] cpu_readdata,
  output logic        cpu_wait,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_ack,
  output logic        bus_error,
  output logic        vga_range_err
);

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

  state_t     state;
  state_t     next_state;
  logic [3:0] streak;
  logic       timeout_hit;
  logic       grant_vga;
  logic       grant_cpu;
  logic       req_active;
  logic       vga_done;
  logic       enter_cpu;
  logic       enter_vga;

  assign grant_vga  = (state == GRANT_VGA);
  assign grant_cpu  = (state == GRANT_CPU);
  assign req_active = (grant_vga && vga_read) || (grant_cpu && cpu_cyc);
  assign vga_done   = grant_vga && (mem_ack || timeout_hit);
  assign enter_cpu  = (state == IDLE) && (next_state == GRANT_CPU);
  assign enter_vga  = (state == IDLE) && (next_state == GRANT_VGA);

  // Counter is held clear in IDLE, so every grant starts from zero.
  vidmem_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state == IDLE),
    .enable  (req_active && !mem_ack),
    .hit     (timeout_hit)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      streak        <= '0;
      bus_error     <= 1'b0;
      vga_range_err <= 1'b0;
    end else begin
      state         <= next_state;
      bus_error     <= timeout_hit;
      vga_range_err <= enter_vga && !in_window(vga_address, VIDMEM, VIDSIZE);
      if (!cpu_cyc || enter_cpu) begin
        streak <= '0;
      end else if (vga_done && (streak < STREAK_MAX)) begin
        streak <= streak + 1'b1;
      end
    end
  end

  always_comb begin
    next_state    = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    unique case (state)
      IDLE: begin
        if (vga_read && cpu_cyc) begin
          next_state = (streak == STREAK_MAX) ? GRANT_CPU : GRANT_VGA;
        end else if (vga_read) begin
          next_state = GRANT_VGA;
        end else if (cpu_cyc) begin
          next_state = GRANT_CPU;
        end
      end
      GRANT_VGA: begin
        mem_req     = 1'b1;
        mem_address = vga_address;
        if (!vga_read || mem_ack || timeout_hit) next_state = IDLE;
      end
      GRANT_CPU: begin
        mem_req       = 1'b1;
        mem_we        = cpu_we;
        mem_address   = cpu_address;
        mem_writedata = cpu_writedata;
        if (!cpu_cyc || mem_ack || timeout_hit) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // An aborted transfer completes with zero data rather than bus garbage.
  assign vga_wait     = vga_read && !(grant_vga && (mem_ack || timeout_hit));
  assign cpu_wait     = cpu_cyc && !(grant_cpu && (mem_ack || timeout_hit));
  assign vga_data     = timeout_hit ? 24'h0 : mem_readdata[23:0];
  assign cpu_readdata = timeout_hit ? 32'h0 : mem_readdata;

endmodule
